// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, half-bit aligned sampling FSM,
// and a CPU-visible data register with ready, overrun and framing-error flags.
module uart_rx #(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic       sysclk,
   input  logic       Reset,
   input  logic       UART_IN,
   input  logic       rd,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      WAIT_HI = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bitidx_q, bitidx_d;
   logic [7:0]       shift_q, shift_d;
   logic             sync1_q, in_s_q;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_ready_q, rx_ready_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic             busy_q, busy_d;
   logic             byte_done_s;
   logic             frame_bad_s;

   // Input synchronizer; resets to the idle (high) line level.
   always_ff @(posedge sysclk) begin
      if (Reset) begin
         sync1_q <= 1'b1;
         in_s_q  <= 1'b1;
      end else begin
         sync1_q <= UART_IN;
         in_s_q  <= sync1_q;
      end
   end

   // Receiver state and output registers.
   always_ff @(posedge sysclk) begin
      if (Reset) begin
         state_q     <= IDLE;
         cnt_q       <= CNT_ZERO;
         bitidx_q    <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_ready_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bitidx_q    <= bitidx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_ready_q  <= rx_ready_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state logic: START waits half a bit so DATA/STOP sample bit centres.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitidx_d    = bitidx_q;
      shift_d     = shift_q;
      byte_done_s = 1'b0;
      frame_bad_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (!in_s_q) begin
               state_d = START;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = CNT_ZERO;
               if (!in_s_q) begin
                  state_d  = DATA;
                  bitidx_d = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               shift_d[bitidx_q] = in_s_q;
               cnt_d             = CNT_ZERO;
               bitidx_d          = bitidx_q + 3'd1;
               if (bitidx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  state_d = DATA;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = CNT_ZERO;
               if (in_s_q) begin
                  byte_done_s = 1'b1;
                  state_d     = IDLE;
               end else begin
                  frame_bad_s = 1'b1;
                  state_d     = WAIT_HI;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         WAIT_HI: begin
            if (in_s_q) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_HI;
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = CNT_ZERO;
            bitidx_d = 3'd0;
         end
      endcase
   end

   // Status flags: a set event in the same cycle as rd takes priority over the clear.
   always_comb begin
      rx_data_d   = rx_data_q;
      rx_ready_d  = rx_ready_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;

      if (byte_done_s) begin
         rx_data_d = shift_q;
      end else begin
         rx_data_d = rx_data_q;
      end

      if (byte_done_s) begin
         rx_ready_d = 1'b1;
      end else if (rd) begin
         rx_ready_d = 1'b0;
      end else begin
         rx_ready_d = rx_ready_q;
      end

      if (byte_done_s && rx_ready_q && !rd) begin
         overrun_d = 1'b1;
      end else if (rd) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end

      if (frame_bad_s) begin
         frame_err_d = 1'b1;
      end else if (rd) begin
         frame_err_d = 1'b0;
      end else begin
         frame_err_d = frame_err_q;
      end

      busy_d = (state_d != IDLE);
   end

   assign rx_data   = rx_data_q;
   assign rx_ready  = rx_ready_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; expected bytes are
// queued when a frame is driven and compared when the receiver presents them.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk;
   logic       Reset;
   logic       UART_IN;
   logic       rd;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       overrun;
   logic       frame_err;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         rise_cyc = -1;
   logic       ready_prev = 1'b0;
   int         t_start;
   logic [7:0] exp_q[$];
   logic [7:0] last_good;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .sysclk   (clk),
      .Reset    (Reset),
      .UART_IN  (UART_IN),
      .rd       (rd),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .overrun  (overrun),
      .frame_err(frame_err),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Cycle stamp of each rx_ready rising edge.
   always @(negedge clk) begin
      if (rx_ready && !ready_prev) rise_cyc <= cyc;
      ready_prev <= rx_ready;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one 8N1 frame; rd is pulsed in cycle rd_at of the frame (-1 for none).
   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int rd_at);
      logic [9:0] frame;
      frame   = {stop_bit, b, 1'b0};
      t_start = cyc;
      if (stop_bit) exp_q.push_back(b);
      for (int c = 0; c < 10 * CPB; c++) begin
         UART_IN = frame[c / CPB];
         rd      = (c == rd_at);
         tick(1);
      end
      rd = 1'b0;
   endtask

   task automatic sb_pop(output logic [7:0] e);
      if (exp_q.size() == 0) e = 8'hxx;
      else e = exp_q.pop_front();
   endtask

   task automatic pulse_rd();
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; UART_IN = 1'b1; rd = 1'b0;
      tick(3);
      Reset = 1'b0;
      tick(1);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rx_ready); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      last_good = 8'h00;
   endtask

   task automatic test_basic();
      logic [7:0] e;
      rise_cyc = -1;
      send_byte(8'hA5, 1'b1, -1);
      sb_pop(e);
      last_good = e;
      checks++; if (rise_cyc < t_start + 153 || rise_cyc > t_start + 157) begin
         errors++; $display("FAIL basic_latency: got %0d cycles expected 155+-2", rise_cyc - t_start); end
      checks++; if (rx_data !== e) begin errors++; $display("FAIL basic_data: got %h expected %h", rx_data, e); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", rx_ready); end
      checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
         errors++; $display("FAIL basic_flags: got fe=%b ov=%b expected 0 0", frame_err, overrun); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
      pulse_rd();
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL basic_rd_clear: got %b expected 0", rx_ready); end
      checks++; if (rx_data !== e) begin errors++; $display("FAIL basic_data_hold: got %h expected %h", rx_data, e); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      send_byte(8'h00, 1'b1, -1);
      send_byte(8'hFF, 1'b1, -1);
      sb_pop(e);   // 0x00 is overwritten by the second byte
      sb_pop(e);
      last_good = e;
      checks++; if (rx_data !== e) begin errors++; $display("FAIL b2b_data: got %h expected %h", rx_data, e); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", rx_ready); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
      pulse_rd();
      checks++; if (rx_ready !== 1'b0 || overrun !== 1'b0) begin
         errors++; $display("FAIL b2b_rd_clear: got rdy=%b ov=%b expected 0 0", rx_ready, overrun); end
   endtask

   task automatic test_frame_err();
      logic [7:0] e;
      send_byte(8'h3C, 1'b0, -1);
      UART_IN = 1'b0;
      tick(3 * CPB);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_flag: got %b expected 1", frame_err); end
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL fe_ready: got %b expected 0", rx_ready); end
      checks++; if (rx_data !== last_good) begin errors++; $display("FAIL fe_data: got %h expected %h", rx_data, last_good); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fe_busy_low: got %b expected 1", busy); end
      UART_IN = 1'b1;
      tick(5);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_busy_high: got %b expected 0", busy); end
      send_byte(8'h5A, 1'b1, -1);
      sb_pop(e);
      last_good = e;
      checks++; if (rx_data !== e || rx_ready !== 1'b1) begin
         errors++; $display("FAIL fe_next_byte: got %h rdy=%b expected %h rdy=1", rx_data, rx_ready, e); end
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_sticky: got %b expected 1", frame_err); end
      pulse_rd();
      checks++; if (frame_err !== 1'b0 || rx_ready !== 1'b0) begin
         errors++; $display("FAIL fe_rd_clear: got fe=%b rdy=%b expected 0 0", frame_err, rx_ready); end
   endtask

   task automatic test_glitch();
      UART_IN = 1'b0;
      tick(4);
      UART_IN = 1'b1;
      tick(2);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start_seen: got %b expected 1", busy); end
      tick(20);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", busy); end
      checks++; if (rx_ready !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
         errors++; $display("FAIL glitch_flags: got rdy=%b ov=%b fe=%b expected 0 0 0", rx_ready, overrun, frame_err); end
      checks++; if (rx_data !== last_good) begin errors++; $display("FAIL glitch_data: got %h expected %h", rx_data, last_good); end
   endtask

   task automatic test_reset_midframe();
      logic [9:0] frame;
      logic [7:0] e;
      frame = {1'b1, 8'h81, 1'b0};
      for (int c = 0; c < 4 * CPB + CPB + CPB / 2; c++) begin
         UART_IN = frame[c / CPB];
         tick(1);
      end
      Reset = 1'b1;
      tick(1);
      Reset   = 1'b0;
      UART_IN = 1'b1;
      checks++; if (rx_data !== 8'h00 || rx_ready !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midreset_outputs: got data=%h rdy=%b ov=%b fe=%b busy=%b expected all 0",
                            rx_data, rx_ready, overrun, frame_err, busy); end
      tick(10);
      checks++; if (busy !== 1'b0 || rx_ready !== 1'b0) begin
         errors++; $display("FAIL midreset_quiet: got busy=%b rdy=%b expected 0 0", busy, rx_ready); end
      send_byte(8'h42, 1'b1, -1);
      sb_pop(e);
      last_good = e;
      checks++; if (rx_data !== e || rx_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_next: got %h rdy=%b expected %h rdy=1", rx_data, rx_ready, e); end
      checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
         errors++; $display("FAIL midreset_flags: got fe=%b ov=%b expected 0 0", frame_err, overrun); end
      pulse_rd();
   endtask

   task automatic test_rd_collision();
      logic [7:0] e;
      send_byte(8'h11, 1'b1, -1);
      sb_pop(e);
      checks++; if (rx_data !== e || rx_ready !== 1'b1) begin
         errors++; $display("FAIL coll_pending: got %h rdy=%b expected %h rdy=1", rx_data, rx_ready, e); end
      tick(3);
      send_byte(8'h77, 1'b1, 155 - 1);
      sb_pop(e);
      last_good = e;
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL coll_ready: got %b expected 1", rx_ready); end
      checks++; if (rx_data !== e) begin errors++; $display("FAIL coll_data: got %h expected %h", rx_data, e); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coll_overrun: got %b expected 0", overrun); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_reset_midframe();
      test_rd_collision();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
